// File: rtl/timestamped_register_model.sv
// Token-level register model: turns timestamped clock/d change streams into a q change stream.
// Edge token accepted in cycle N yields q_out_valid in N+1; an edge that must emit stalls while the output register is full.
module timestamped_register_model #(
  parameter int DATA_WIDTH = 1,
  parameter int TIME_WIDTH = 64,
  parameter int POSEDGE    = 1,
  parameter int INIT_VALUE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clk_in_valid,
  output logic                  clk_in_ready,
  input  logic [TIME_WIDTH-1:0] clk_in_time,
  input  logic                  clk_in_value,
  input  logic                  d_in_valid,
  output logic                  d_in_ready,
  input  logic [TIME_WIDTH-1:0] d_in_time,
  input  logic [DATA_WIDTH-1:0] d_in_data,
  output logic                  q_out_valid,
  input  logic                  q_out_ready,
  output logic [TIME_WIDTH-1:0] q_out_time,
  output logic [DATA_WIDTH-1:0] q_out_data,
  output logic                  error
);

  localparam logic                  L_ACT  = (POSEDGE != 0);
  localparam logic [DATA_WIDTH-1:0] L_INIT = DATA_WIDTH'(INIT_VALUE);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_clk_last;
  logic                  r_clk_seen;
  logic [TIME_WIDTH-1:0] r_clk_last_time;
  logic                  r_d_seen;
  logic [TIME_WIDTH-1:0] r_d_last_time;
  logic [DATA_WIDTH-1:0] r_d_cur;
  logic [DATA_WIDTH-1:0] r_q_cur;
  logic                  r_out_vld;
  logic [TIME_WIDTH-1:0] r_out_time;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_error;

  logic w_d_first;
  logic w_edge;
  logic w_need_out;
  logic w_out_free;
  logic w_clk_acc;
  logic w_d_acc;
  logic w_load;

  // Ties go to the clock so an edge samples d as it was strictly before the edge.
  assign w_d_first  = d_in_time < clk_in_time;
  assign w_edge     = r_clk_seen && (r_clk_last != L_ACT) && (clk_in_value == L_ACT);
  assign w_need_out = w_edge && (r_d_cur != r_q_cur);
  assign w_out_free = !r_out_vld || q_out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clk_acc   = 1'b0;
    w_d_acc     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_INIT: begin
        if (r_out_vld && q_out_ready) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (clk_in_valid && d_in_valid) begin
          if (w_d_first) begin
            w_d_acc = 1'b1;
          end else if (!w_need_out) begin
            w_clk_acc = 1'b1;
          end else if (w_out_free) begin
            w_clk_acc = 1'b1;
            w_load    = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
    if (reset) begin
      w_clk_acc = 1'b0;
      w_d_acc   = 1'b0;
      w_load    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_last      <= 1'b0;
      r_clk_seen      <= 1'b0;
      r_clk_last_time <= '0;
      r_d_seen        <= 1'b0;
      r_d_last_time   <= '0;
      r_d_cur         <= L_INIT;
      r_q_cur         <= L_INIT;
      r_out_vld       <= 1'b0;
      r_out_time      <= '0;
      r_out_data      <= L_INIT;
      r_error         <= 1'b0;
    end else begin
      if (r_state == S_INIT) begin
        if (r_out_vld && q_out_ready) begin
          r_out_vld <= 1'b0;
        end else begin
          r_out_vld  <= 1'b1;
          r_out_time <= '0;
          r_out_data <= L_INIT;
        end
      end else if (w_load) begin
        r_out_vld  <= 1'b1;
        r_out_time <= clk_in_time;
        r_out_data <= r_d_cur;
        r_q_cur    <= r_d_cur;
      end else if (q_out_ready) begin
        r_out_vld <= 1'b0;
      end

      if (w_d_acc) begin
        r_d_cur       <= d_in_data;
        r_d_seen      <= 1'b1;
        r_d_last_time <= d_in_time;
        if (r_d_seen && (d_in_time <= r_d_last_time)) begin
          r_error <= 1'b1;
        end
      end

      if (w_clk_acc) begin
        r_clk_last      <= clk_in_value;
        r_clk_seen      <= 1'b1;
        r_clk_last_time <= clk_in_time;
        if (r_clk_seen && (clk_in_time <= r_clk_last_time)) begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign clk_in_ready = w_clk_acc;
  assign d_in_ready   = w_d_acc;
  assign q_out_valid  = r_out_vld;
  assign q_out_time   = r_out_time;
  assign q_out_data   = r_out_data;
  assign error        = r_error;

endmodule

// File: tb/tb_timestamped_register_model.sv
// Bench for timestamped_register_model: a rising-edge and a falling-edge instance (DATA_WIDTH 4, INIT_VALUE 5).
module tb_timestamped_register_model;

  typedef struct packed {
    logic [63:0] t;
    logic [3:0]  v;
  } tv_t;

  typedef struct packed {
    logic [7:0]  sc;
    logic        is_clk;
    logic [63:0] t;
    logic [3:0]  v;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        tb_clk_vld = 1'b0;
  logic        tb_clk_val = 1'b0;
  logic [63:0] tb_clk_time = '0;
  logic        tb_d_vld = 1'b0;
  logic [63:0] tb_d_time = '0;
  logic [3:0]  tb_d_dat = '0;
  logic        tb_q_rdy = 1'b1;

  logic        p_clk_rdy, p_d_rdy, p_q_vld, p_err;
  logic [63:0] p_q_time;
  logic [3:0]  p_q_dat;
  logic        n_clk_rdy, n_d_rdy, n_q_vld, n_err;
  logic [63:0] n_q_time;
  logic [3:0]  n_q_dat;

  logic        w_clk_rdy, w_d_rdy, w_q_vld, w_err;
  logic [63:0] w_q_time;
  logic [3:0]  w_q_dat;

  int n_chk  = 0;
  int n_pass = 0;

  tv_t  cq[$];
  tv_t  dq[$];
  tv_t  sb[$];
  vec_t vecs[$];
  vec_t exps[$];

  always #5 clk = ~clk;

  timestamped_register_model #(.DATA_WIDTH(4), .TIME_WIDTH(64), .POSEDGE(1), .INIT_VALUE(5)) u_pos (
    .clock(clk), .reset(rst),
    .clk_in_valid(tb_clk_vld & ~sel), .clk_in_ready(p_clk_rdy),
    .clk_in_time(tb_clk_time), .clk_in_value(tb_clk_val),
    .d_in_valid(tb_d_vld & ~sel), .d_in_ready(p_d_rdy),
    .d_in_time(tb_d_time), .d_in_data(tb_d_dat),
    .q_out_valid(p_q_vld), .q_out_ready(tb_q_rdy & ~sel),
    .q_out_time(p_q_time), .q_out_data(p_q_dat), .error(p_err)
  );

  timestamped_register_model #(.DATA_WIDTH(4), .TIME_WIDTH(64), .POSEDGE(0), .INIT_VALUE(5)) u_neg (
    .clock(clk), .reset(rst),
    .clk_in_valid(tb_clk_vld & sel), .clk_in_ready(n_clk_rdy),
    .clk_in_time(tb_clk_time), .clk_in_value(tb_clk_val),
    .d_in_valid(tb_d_vld & sel), .d_in_ready(n_d_rdy),
    .d_in_time(tb_d_time), .d_in_data(tb_d_dat),
    .q_out_valid(n_q_vld), .q_out_ready(tb_q_rdy & sel),
    .q_out_time(n_q_time), .q_out_data(n_q_dat), .error(n_err)
  );

  assign w_clk_rdy = sel ? n_clk_rdy : p_clk_rdy;
  assign w_d_rdy   = sel ? n_d_rdy   : p_d_rdy;
  assign w_q_vld   = sel ? n_q_vld   : p_q_vld;
  assign w_err     = sel ? n_err     : p_err;
  assign w_q_time  = sel ? n_q_time  : p_q_time;
  assign w_q_dat   = sel ? n_q_dat   : p_q_dat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_sb(input logic [63:0] t, input logic [3:0] v);
    tv_t e;
    e.t = t;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic push_tok(input logic is_clk, input logic [63:0] t, input logic [3:0] v);
    tv_t e;
    e.t = t;
    e.v = v;
    if (is_clk) cq.push_back(e);
    else dq.push_back(e);
  endtask

  task automatic add_vec(input logic [7:0] sc, input logic is_clk, input logic [63:0] t, input logic [3:0] v);
    vec_t e;
    e.sc = sc; e.is_clk = is_clk; e.t = t; e.v = v;
    vecs.push_back(e);
  endtask

  task automatic add_exp(input logic [7:0] sc, input logic [63:0] t, input logic [3:0] v);
    vec_t e;
    e.sc = sc; e.is_clk = 1'b0; e.t = t; e.v = v;
    exps.push_back(e);
  endtask

  // One host cycle, entered and left just after a falling edge.
  task automatic step();
    logic f_clk, f_d, f_q;
    tv_t  e;
    tb_clk_vld = (cq.size() > 0);
    if (cq.size() > 0) begin
      tb_clk_time = cq[0].t;
      tb_clk_val  = cq[0].v[0];
    end
    tb_d_vld = (dq.size() > 0);
    if (dq.size() > 0) begin
      tb_d_time = dq[0].t;
      tb_d_dat  = dq[0].v;
    end
    #1;
    f_clk = tb_clk_vld && w_clk_rdy;
    f_d   = tb_d_vld && w_d_rdy;
    f_q   = w_q_vld && tb_q_rdy;
    if (f_q) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_q: got t=%0d d=%0h, expected no token", w_q_time, w_q_dat);
      end else begin
        e = sb.pop_front();
        check("q_time", w_q_time, e.t);
        check("q_data", 64'(w_q_dat), 64'(e.v));
      end
    end
    @(posedge clk);
    if (f_clk) void'(cq.pop_front());
    if (f_d) void'(dq.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int budget);
    int k = 0;
    while ((sb.size() != 0 || cq.size() != 0) && k < budget) begin
      step();
      k++;
    end
    repeat (3) step();
    n_chk++;
    if (sb.size() == 0 && cq.size() == 0) n_pass++;
    else $display("FAIL drain: %0d q tokens and %0d clk tokens left, expected 0 and 0", sb.size(), cq.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cq.delete();
    dq.delete();
    sb.delete();
    tb_clk_vld = 1'b1;
    tb_clk_time = '0;
    tb_d_vld = 1'b1;
    tb_d_time = 64'd1;
    repeat (3) @(negedge clk);
    check("rst_q_vld", 64'(w_q_vld), 64'd0);
    check("rst_clk_rdy", 64'(w_clk_rdy), 64'd0);
    check("rst_d_rdy", 64'(w_d_rdy), 64'd0);
    check("rst_err", 64'(w_err), 64'd0);
    check("rst_q_time", w_q_time, 64'd0);
    check("rst_q_data", 64'(w_q_dat), 64'd5);
    tb_clk_vld = 1'b0;
    tb_d_vld = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // sc0 basic capture, sc1 tie rule, sc2 falling edge, sc3 first clock token at 1 is not an edge
    add_vec(0, 1, 0, 0);  add_vec(0, 1, 10, 1); add_vec(0, 1, 20, 0); add_vec(0, 1, 30, 1);
    add_vec(0, 0, 5, 3);  add_vec(0, 0, 100, 3);
    add_exp(0, 10, 3);
    add_vec(1, 0, 0, 1);  add_vec(1, 0, 10, 2); add_vec(1, 0, 50, 2);
    add_vec(1, 1, 0, 0);  add_vec(1, 1, 10, 1); add_vec(1, 1, 20, 0); add_vec(1, 1, 30, 1);
    add_exp(1, 10, 1);    add_exp(1, 30, 2);
    add_vec(2, 1, 0, 1);  add_vec(2, 1, 10, 0); add_vec(2, 1, 20, 1); add_vec(2, 1, 30, 0);
    add_vec(2, 0, 0, 7);  add_vec(2, 0, 40, 7);
    add_exp(2, 10, 7);
    add_vec(3, 1, 5, 1);  add_vec(3, 1, 10, 0); add_vec(3, 1, 20, 1);
    add_vec(3, 0, 0, 9);  add_vec(3, 0, 30, 9);
    add_exp(3, 20, 9);

    @(negedge clk);

    // Init token is held with inputs pending and neither input is accepted.
    sel = 1'b0;
    tb_q_rdy = 1'b1;
    do_reset();
    tb_q_rdy = 1'b0;
    push_tok(1, 0, 0);
    push_tok(0, 5, 1);
    step();
    check("init_q_vld", 64'(w_q_vld), 64'd1);
    check("init_q_time", w_q_time, 64'd0);
    check("init_q_data", 64'(w_q_dat), 64'd5);
    check("init_clk_rdy", 64'(w_clk_rdy), 64'd0);
    check("init_d_rdy", 64'(w_d_rdy), 64'd0);
    step();
    check("init_hold_clk_rdy", 64'(w_clk_rdy), 64'd0);
    check("init_hold_q_vld", 64'(w_q_vld), 64'd1);
    tb_q_rdy = 1'b1;
    push_sb(0, 5);
    run(50);

    for (int sc = 0; sc < 4; sc++) begin
      sel = (sc == 2);
      tb_q_rdy = 1'b1;
      do_reset();
      foreach (vecs[i]) if (vecs[i].sc == 8'(sc)) push_tok(vecs[i].is_clk, vecs[i].t, vecs[i].v);
      push_sb(0, 5);
      foreach (exps[i]) if (exps[i].sc == 8'(sc)) push_sb(exps[i].t, exps[i].v);
      run(200);
      check("scen_err", 64'(w_err), 64'd0);
    end

    // Backpressure: second changing edge waits behind a stalled q token.
    sel = 1'b0;
    tb_q_rdy = 1'b1;
    do_reset();
    push_tok(1, 0, 0);  push_tok(1, 10, 1); push_tok(1, 20, 0); push_tok(1, 30, 1);
    push_tok(0, 5, 1);  push_tok(0, 25, 2); push_tok(0, 100, 2);
    push_sb(0, 5);
    repeat (2) step();
    tb_q_rdy = 1'b0;
    repeat (10) step();
    check("bp_q_vld", 64'(w_q_vld), 64'd1);
    check("bp_clk_rdy", 64'(w_clk_rdy), 64'd0);
    check("bp_clk_left", 64'(cq.size()), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_time", w_q_time, 64'd10);
      check("bp_hold_data", 64'(w_q_dat), 64'd1);
      step();
    end
    push_sb(10, 1);
    push_sb(30, 2);
    tb_q_rdy = 1'b1;
    run(50);

    // Duplicate d timestamp sets a sticky error; reset clears it and drops the pending token.
    tb_q_rdy = 1'b1;
    do_reset();
    push_tok(1, 0, 0);  push_tok(1, 20, 1); push_tok(1, 30, 0);
    push_tok(0, 10, 3); push_tok(0, 10, 4); push_tok(0, 200, 4);
    push_sb(0, 5);
    repeat (2) step();
    tb_q_rdy = 1'b0;
    repeat (8) step();
    check("err_set", 64'(w_err), 64'd1);
    check("err_pending_vld", 64'(w_q_vld), 64'd1);
    check("err_pending_time", w_q_time, 64'd20);
    check("err_pending_data", 64'(w_q_dat), 64'd4);
    repeat (3) step();
    check("err_sticky", 64'(w_err), 64'd1);
    tb_q_rdy = 1'b1;
    do_reset();
    push_sb(0, 5);
    run(20);
    check("err_after_reset", 64'(w_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timestamped_register_model.md
# timestamped_register_model

Synthesizable, token-level model of a clocked register for the midas timestamped-simulation layer. It consumes timestamped value-change streams for a clock and a data input and produces a timestamped value-change stream for the register output. On each active clock edge, q takes the value d held strictly before the edge time; a d change at the same timestamp as the edge is not seen. It is the host-side counterpart that lets timestamped sinks be checked against event-driven register models.

## Interface
- DATA_WIDTH, 1: width of d and q.
- TIME_WIDTH, 64: timestamp width, unsigned.
- POSEDGE, 1: 1 = rising edge active; 0 = falling edge active.
- INIT_VALUE, 0: q value at time 0, truncated to DATA_WIDTH.
- clock  in  1  host clock; every port is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- clk_in_valid  in  1  clock change token present.
- clk_in_ready  out  1  clock token accepted when valid && ready.
- clk_in_time  in  TIME_WIDTH  timestamp of the clock change.
- clk_in_value  in  1  new clock level.
- d_in_valid  in  1  d change token present.
- d_in_ready  out  1  d token accepted when valid && ready.
- d_in_time  in  TIME_WIDTH  timestamp of the d change.
- d_in_data  in  DATA_WIDTH  new d value.
- q_out_valid  out  1  q change token present.
- q_out_ready  in  1  downstream accepts the q token.
- q_out_time  out  TIME_WIDTH  timestamp of the q change.
- q_out_data  out  DATA_WIDTH  new q value.
- error  out  1  sticky flag: a stream violated timestamp monotonicity.

## Operation
- **Token streams:**
  - Each input stream is a sequence of value changes with strictly increasing timestamps.
  - The first token of each stream defines its initial level, normally at time 0.
- **FSM states:** INIT and RUN.
- **INIT:**
  - Entered on reset.
  - Presents q token (time 0, INIT_VALUE).
  - Both input readies are 0.
  - Moves to RUN when the token handshakes.
- **RUN state:**
  - clk_last, clk_seen = 0, d_cur = INIT_VALUE, q_cur = INIT_VALUE, 1-entry output register.
- **Arbitration (RUN):** acts only when both clk_in_valid and d_in_valid are 1; otherwise it stalls with both readies 0.
  - If d_in_time < clk_in_time: accept d; d_cur <= d_in_data.
  - If d_in_time >= clk_in_time: accept the clock token.
  - The tie goes to the clock, so an edge samples the old d.
- **Clock token handling:**
  - The token is an active edge iff clk_seen && clk_last == !POSEDGE && clk_in_value == POSEDGE.
  - clk_last <= clk_in_value; clk_seen <= 1.
  - The first clock token is never an edge, even if its value is 1.
- **Edge with d_cur != q_cur:**
  - Load output register (clk_in_time, d_cur); q_cur <= d_cur.
  - The clock token is accepted only when the output register is empty or drains this cycle (q_out_valid && q_out_ready).
  - Otherwise clk_in_ready = 0.
- **Edge with d_cur == q_cur:** accept; no q token (q stream carries changes only).
- **Monotonicity check:**
  - Each stream tracks its last accepted timestamp.
  - A token whose time is <= that timestamp, on any token after the first, sets error.
  - The token is still processed.
  - error clears only on reset.
- **Timestamp arithmetic:** comparison is unsigned at full TIME_WIDTH; there is no wrap handling.

## Timing
- **Outputs while reset is high:** q_out_valid 0, clk_in_ready 0, d_in_ready 0, error 0, q_out_time 0, q_out_data INIT_VALUE.
- **First cycle after reset:** q_out_valid 1, time 0, data INIT_VALUE.
- **Throughput:** one input token accepted per cycle at most.
- **Latency:** an edge token accepted in cycle N gives q_out_valid = 1 in cycle N+1.
- **Output hold:** q_out_* stay stable while q_out_valid && !q_out_ready.
- **Reset mid-operation:** drops any pending output token, clears all state, and re-enters INIT next cycle.
- **Combinational paths:** readies depend combinationally on valids, timestamps and q_out_ready. There is no combinational path from any input to q_out_*.

## Test plan
- **Reset and init:**
  - Stimulus: reset for 3 cycles, then release, q_out_ready = 1.
  - Response: q token (0, INIT_VALUE = 0x5, DATA_WIDTH = 4) exactly once, with no input accepted before it.
- **Basic capture:**
  - Stimulus: clk tokens (0,0), (10,1), (20,0), (30,1); d tokens (5,0x3), (100,0x3).
  - Response: q tokens (10,0x3) only.
- **Tie rule:**
  - Stimulus: d tokens (0,0x1), (10,0x2), (50,0x2); clk tokens (0,0), (10,1), (20,0), (30,1).
  - Response: q tokens (10,0x1), (30,0x2).
- **NEGEDGE and first-token edge suppression:**
  - Stimulus: POSEDGE = 0; clk tokens (0,1), (10,0), (20,1), (30,0); d tokens (0,0x7), (40,0x7).
  - Response: q tokens (10,0x7) only; no edge at time 0.
- **Backpressure:**
  - Stimulus: hold q_out_ready = 0 with a pending q token while a second changing edge is presented.
  - Response: clk_in_ready = 0 and q_out fields stable; release gives both tokens in order, none lost.
- **Error and reset mid-run:**
  - Stimulus: d tokens (10,..), (10,..).
  - Response: error = 1 and stays 1. Asserting reset mid-run clears error, drops the pending q token, and the init token reappears.
